const_table: RTL and testbench
==============================

CONST_TABLE -- requirements
Module: const_table

Interface
REQ-001 The block SHALL have parameter DW, default 8: data width of constants and of the constant output (DW >= 8).
REQ-002 The block SHALL have parameter PW, default 5: operand pointer width; DEPTH = 2^(PW-1) table entries.
REQ-003 The block SHALL have port Clk, input, 1: single clock; all state updates on rising edge.
REQ-004 The block SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1: lookup request qualifier.
REQ-006 The block SHALL have port ptr, input, PW: operand pointer; MSB=1 selects a table entry, MSB=0 selects a register number.
REQ-007 The block SHALL have port wr_en, input, 1: table write strobe.
REQ-008 The block SHALL have port wr_addr, input, PW-1: table entry to write.
REQ-009 The block SHALL have port wr_data, input, DW: value to write.
REQ-010 The block SHALL have port rsp_valid, output, 1: lookup result valid.
REQ-011 The block SHALL have port constant, output, DW: table value, or zero-extended register number.
REQ-012 The block SHALL have port const_flag, output, 1: 1 = table constant, 0 = register pointer.
REQ-013 The block SHALL have port init_busy, output, 1: table initialisation in progress; requests are not accepted.

Function
REQ-014 The block SHALL implement a two-state FSM: INIT (table load) and READY (service).
REQ-015 In INIT, the block SHALL write the default entry for index idx each cycle, idx counting 0..DEPTH-1, then enter READY on the cycle after idx=DEPTH-1 is written.
REQ-016 Default entries 0..15 SHALL be: 127,1,2,128,8,3,4,5,32,6,15,64,7,255,19,20, each zero-extended to DW.
REQ-017 Entries 16 and above SHALL default to 0.
REQ-018 When DEPTH<16, only the first DEPTH default entries SHALL be loaded.
REQ-019 init_busy SHALL be 1 in INIT and 0 in READY.
REQ-020 In INIT, req_valid and wr_en SHALL be ignored; rsp_valid SHALL stay 0.
REQ-021 In READY, req_valid=1 at edge N SHALL produce rsp_valid=1 at edge N+1 (1-cycle latency) with the results below; one request per cycle, no back-pressure.
REQ-022 For ptr MSB=1, the result SHALL be constant = table[ptr[PW-2:0]] and const_flag = 1.
REQ-023 For ptr MSB=0, the result SHALL be constant = {zeros, ptr[PW-2:0]} and const_flag = 0.
REQ-024 With req_valid=0, rsp_valid SHALL be 0 on the next cycle, and constant/const_flag SHALL hold their previous values.
REQ-025 In READY, wr_en=1 SHALL write wr_data into table[wr_addr] at the edge.
REQ-026 For a simultaneous write and table request to the same entry, the response SHALL return wr_data (write-first bypass).
REQ-027 A write to a different entry in the same cycle SHALL not affect the response.
REQ-028 Written values SHALL persist until overwritten or until Reset.

Reset
REQ-029 While Reset=1, the block SHALL hold: state=INIT, idx=0, rsp_valid=0, constant=0, const_flag=0, init_busy=1.
REQ-030 The first default write SHALL occur on the first edge with Reset=0, and init_busy SHALL fall DEPTH cycles after Reset release.
REQ-031 Reset asserted during INIT SHALL restart the load at idx 0.
REQ-032 Reset asserted during READY SHALL discard all user writes; defaults SHALL be reloaded by a full INIT sequence.
REQ-033 A request accepted in the cycle Reset asserts SHALL produce no response.

Verification
REQ-034 The bench SHALL cover: default params, Reset for 2 cycles then release -> init_busy=1 for exactly 16 cycles; req_valid asserted during this window -> rsp_valid never 1.
REQ-035 The bench SHALL cover: after INIT, ptr=5'b10000 then 5'b11101 on consecutive cycles -> responses 127/flag1 then 255/flag1, each 1 cycle later, back-to-back rsp_valid.
REQ-036 The bench SHALL cover: ptr=5'b00111 -> constant=8'h07, const_flag=0; ptr=5'b01111 -> 8'h0F, const_flag=0.
REQ-037 The bench SHALL cover: wr_en, wr_addr=3, wr_data=8'hA5, with same-cycle request ptr=5'b10011 -> response 8'hA5; a later request to ptr=5'b10011 -> 8'hA5; same-cycle request to 5'b10100 -> 8.
REQ-038 The bench SHALL cover: write 8'h3C to entry 0, then Reset pulse in READY, then INIT completion, then ptr=5'b10000 -> 127 (default restored); Reset at INIT cycle 7 -> init_busy lasts 16 cycles from the new release.
REQ-039 The bench SHALL cover: DW=16, PW=6 -> INIT lasts 32 cycles; ptr=6'b100011 -> 16'h0080; ptr=6'b110000 -> 16'h0000, const_flag=1; ptr=6'b010101 -> 16'h0015, const_flag=0.

Source files
------------

// File: rtl/const_table_if.sv
// Lookup/write bus of the constant table: requests and table writes in,
// registered lookup results and the initialisation status out.
interface const_table_if #(
  parameter int DW = 8,
  parameter int PW = 5
);
  logic          req_valid;
  logic [PW-1:0] ptr;
  logic          wr_en;
  logic [PW-2:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rsp_valid;
  logic [DW-1:0] constant;
  logic          const_flag;
  logic          init_busy;

  modport master (
    output req_valid, ptr, wr_en, wr_addr, wr_data,
    input  rsp_valid, constant, const_flag, init_busy
  );

  modport slave (
    input  req_valid, ptr, wr_en, wr_addr, wr_data,
    output rsp_valid, constant, const_flag, init_busy
  );
endinterface

// File: rtl/const_table.sv
// Operand constant table: loads default constants after reset, then resolves
// operand pointers to either a table constant or a zero-extended register number.
module const_table #(
  parameter int DW = 8,
  parameter int PW = 5
) (
  input logic         Clk,
  input logic         Reset,
  const_table_if.slave bus
);
  localparam int AW    = PW - 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {INIT, READY} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   table_mem [DEPTH];
  logic            tbl_we;
  logic [AW-1:0]   tbl_waddr;
  logic [DW-1:0]   tbl_wdata;
  logic [AW-1:0]   sel;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   constant_q, constant_d;
  logic            const_flag_q, const_flag_d;

  function automatic logic [DW-1:0] default_entry(input logic [AW-1:0] i);
    logic [7:0] v;
    case (int'(i))
      0:  v = 8'd127;
      1:  v = 8'd1;
      2:  v = 8'd2;
      3:  v = 8'd128;
      4:  v = 8'd8;
      5:  v = 8'd3;
      6:  v = 8'd4;
      7:  v = 8'd5;
      8:  v = 8'd32;
      9:  v = 8'd6;
      10: v = 8'd15;
      11: v = 8'd64;
      12: v = 8'd7;
      13: v = 8'd255;
      14: v = 8'd19;
      15: v = 8'd20;
      default: v = 8'd0;
    endcase
    return DW'(v);
  endfunction

  assign sel = bus.ptr[AW-1:0];

  // The single table write port is shared: the default loader owns it in INIT,
  // the user write strobe owns it in READY. A same-entry write bypasses to the lookup.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tbl_we       = 1'b0;
    tbl_waddr    = bus.wr_addr;
    tbl_wdata    = bus.wr_data;
    rsp_valid_d  = 1'b0;
    constant_d   = constant_q;
    const_flag_d = const_flag_q;
    case (state_q)
      INIT: begin
        tbl_we    = 1'b1;
        tbl_waddr = idx_q;
        tbl_wdata = default_entry(idx_q);
        idx_d     = idx_q + 1'b1;
        if (idx_q == AW'(DEPTH - 1)) state_d = READY;
      end
      READY: begin
        tbl_we = bus.wr_en;
        if (bus.req_valid) begin
          rsp_valid_d = 1'b1;
          if (bus.ptr[PW-1]) begin
            const_flag_d = 1'b1;
            constant_d   = (bus.wr_en && (bus.wr_addr == sel)) ? bus.wr_data
                                                               : table_mem[sel];
          end else begin
            const_flag_d = 1'b0;
            constant_d   = DW'(sel);
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= INIT;
      idx_q        <= '0;
      rsp_valid_q  <= 1'b0;
      constant_q   <= '0;
      const_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rsp_valid_q  <= rsp_valid_d;
      constant_q   <= constant_d;
      const_flag_q <= const_flag_d;
    end
  end

  // Table contents need no reset; a full INIT pass rewrites every entry.
  always_ff @(posedge Clk) begin
    if (!Reset && tbl_we) table_mem[tbl_waddr] <= tbl_wdata;
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.constant   = constant_q;
  assign bus.const_flag = const_flag_q;
  assign bus.init_busy  = (state_q == INIT);
endmodule

// File: tb/tb_const_table.sv
// Self-checking bench for const_table: a default instance and a DW=16/PW=6
// instance run side by side against a behavioural table model.
module tb_const_table;
  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  const_table_if #(.DW(8),  .PW(5)) bus8 ();
  const_table_if #(.DW(16), .PW(6)) bus16 ();

  const_table #(.DW(8),  .PW(5)) dut8  (.Clk(Clk), .Reset(Reset), .bus(bus8));
  const_table #(.DW(16), .PW(6)) dut16 (.Clk(Clk), .Reset(Reset), .bus(bus16));

  int total = 0;
  int bad   = 0;

  int dflt[16]    = '{127, 1, 2, 128, 8, 3, 4, 5, 32, 6, 15, 64, 7, 255, 19, 20};
  int depth_of[2] = '{16, 32};
  int dw_of[2]    = '{8, 16};

  logic        req[2];
  logic [5:0]  ptr_s[2];
  logic        we[2];
  logic [4:0]  wa[2];
  logic [15:0] wd[2];

  int   m_left[2];
  int   m_tbl[2][32];
  logic m_rsp[2];
  int   m_const[2];
  logic m_flag[2];

  int fall8;
  int fall16;

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus();
    bus8.req_valid  = req[0];
    bus8.ptr        = ptr_s[0][4:0];
    bus8.wr_en      = we[0];
    bus8.wr_addr    = wa[0][3:0];
    bus8.wr_data    = wd[0][7:0];
    bus16.req_valid = req[1];
    bus16.ptr       = ptr_s[1];
    bus16.wr_en     = we[1];
    bus16.wr_addr   = wa[1];
    bus16.wr_data   = wd[1];
  endtask

  // Reference: reset reloads defaults and starts a DEPTH-cycle busy countdown;
  // once ready, a request returns the (write-first) table value or the pointer.
  task automatic model_step(input int k);
    int   sel;
    int   waddr;
    int   mask;
    logic msb;
    mask  = (1 << dw_of[k]) - 1;
    sel   = int'(ptr_s[k]) % depth_of[k];
    waddr = int'(wa[k]) % depth_of[k];
    msb   = (k == 0) ? ptr_s[k][4] : ptr_s[k][5];
    if (Reset) begin
      m_left[k]  = depth_of[k];
      m_rsp[k]   = 1'b0;
      m_const[k] = 0;
      m_flag[k]  = 1'b0;
      for (int e = 0; e < 32; e++) m_tbl[k][e] = (e < 16) ? dflt[e] : 0;
    end else if (m_left[k] > 0) begin
      m_left[k]--;
      m_rsp[k] = 1'b0;
    end else begin
      m_rsp[k] = req[k];
      if (req[k]) begin
        if (msb) begin
          m_flag[k]  = 1'b1;
          m_const[k] = (we[k] && waddr == sel) ? (int'(wd[k]) & mask) : m_tbl[k][sel];
        end else begin
          m_flag[k]  = 1'b0;
          m_const[k] = sel;
        end
      end
      if (we[k]) m_tbl[k][waddr] = int'(wd[k]) & mask;
    end
  endtask

  task automatic cycle();
    apply_stimulus();
    model_step(0);
    model_step(1);
    @(posedge Clk);
    #1;
    check_output("rsp_valid8",  16'(bus8.rsp_valid),   16'(m_rsp[0]));
    check_output("constant8",   16'(bus8.constant),    16'(m_const[0]));
    check_output("const_flag8", 16'(bus8.const_flag),  16'(m_flag[0]));
    check_output("init_busy8",  16'(bus8.init_busy),   16'(m_left[0] > 0));
    check_output("rsp_valid16", 16'(bus16.rsp_valid),  16'(m_rsp[1]));
    check_output("constant16",  bus16.constant,        16'(m_const[1]));
    check_output("const_flag16",16'(bus16.const_flag), 16'(m_flag[1]));
    check_output("init_busy16", 16'(bus16.init_busy),  16'(m_left[1] > 0));
  endtask

  task automatic set_idle();
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0;
      we[k]  = 1'b0;
    end
  endtask

  task automatic set_req(input int k, input logic [5:0] p);
    req[k]   = 1'b1;
    ptr_s[k] = p;
  endtask

  task automatic set_wr(input int k, input logic [4:0] a, input logic [15:0] d);
    we[k] = 1'b1;
    wa[k] = a;
    wd[k] = d;
  endtask

  task automatic measure_init(input string tag8, input string tag16);
    fall8  = 0;
    fall16 = 0;
    for (int n = 1; n <= 40; n++) begin
      set_idle();
      req[0]   = (fall8 == 0);
      req[1]   = (fall16 == 0);
      we[0]    = (fall8 == 0);
      we[1]    = (fall16 == 0);
      ptr_s[0] = 6'($urandom);
      ptr_s[1] = 6'($urandom);
      wa[0]    = 5'($urandom);
      wa[1]    = 5'($urandom);
      wd[0]    = 16'($urandom);
      wd[1]    = 16'($urandom);
      cycle();
      if (fall8 == 0 && bus8.init_busy === 1'b0) fall8 = n;
      if (fall16 == 0 && bus16.init_busy === 1'b0) fall16 = n;
    end
    set_idle();
    check_output(tag8,  16'(fall8),  16'd16);
    check_output(tag16, 16'(fall16), 16'd32);
  endtask

  initial begin
    Reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ptr_s[k] = '0;
      wa[k]    = '0;
      wd[k]    = '0;
    end
    set_idle();
    set_req(0, 6'b010000);
    set_req(1, 6'b100000);
    cycle();
    cycle();

    Reset = 1'b0;
    measure_init("init_len8", "init_len16");

    set_req(0, 6'b010000);
    set_req(1, 6'b100011);
    cycle();
    check_output("tbl0_8",    16'(bus8.constant),  16'd127);
    check_output("tbl3_16",   bus16.constant,      16'h0080);
    set_req(0, 6'b011101);
    set_req(1, 6'b110000);
    cycle();
    check_output("tbl13_8",   16'(bus8.constant),  16'd255);
    check_output("b2b_valid", 16'(bus8.rsp_valid), 16'd1);
    check_output("tbl16_16",  bus16.constant,      16'h0000);
    check_output("flag16_tbl",16'(bus16.const_flag), 16'd1);
    set_req(0, 6'b000111);
    set_req(1, 6'b010101);
    cycle();
    check_output("reg7_8",    16'(bus8.constant),  16'h0007);
    check_output("reg7_flag", 16'(bus8.const_flag), 16'd0);
    check_output("reg21_16",  bus16.constant,      16'h0015);
    set_idle();
    set_req(0, 6'b001111);
    cycle();
    check_output("reg15_8",   16'(bus8.constant),  16'h000F);

    set_idle();
    set_wr(0, 5'd3, 16'h00A5);
    set_req(0, 6'b010011);
    cycle();
    check_output("bypass_8",  16'(bus8.constant),  16'h00A5);
    set_idle();
    cycle();
    check_output("hold_8",    16'(bus8.constant),  16'h00A5);
    set_req(0, 6'b010011);
    cycle();
    check_output("persist_8", 16'(bus8.constant),  16'h00A5);
    set_idle();
    set_wr(0, 5'd3, 16'h005A);
    set_req(0, 6'b010100);
    cycle();
    check_output("other_8",   16'(bus8.constant),  16'd8);

    for (int n = 0; n < 200; n++) begin
      for (int k = 0; k < 2; k++) begin
        req[k]   = 1'($urandom);
        ptr_s[k] = 6'($urandom);
        we[k]    = ($urandom_range(0, 2) == 0);
        wa[k]    = ($urandom_range(0, 1) == 0) ? ptr_s[k][4:0] : 5'($urandom);
        wd[k]    = 16'($urandom);
      end
      cycle();
    end

    set_idle();
    set_wr(0, 5'd0, 16'h003C);
    cycle();
    Reset = 1'b1;
    set_idle();
    set_req(0, 6'b010000);
    set_req(1, 6'b100000);
    cycle();
    check_output("rst_no_rsp", 16'(bus8.rsp_valid), 16'd0);
    Reset = 1'b0;
    measure_init("reinit_len8", "reinit_len16");
    set_req(0, 6'b010000);
    cycle();
    check_output("restored_8", 16'(bus8.constant), 16'd127);

    set_idle();
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    for (int n = 0; n < 6; n++) cycle();
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    measure_init("restart_len8", "restart_len16");
    set_req(0, 6'b011110);
    set_req(1, 6'b101110);
    cycle();
    set_idle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
